// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the EX-stage RV32M multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath: operand magnitudes on load, one quotient bit per
// step, sign fix-up applied combinationally on the outputs.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            step,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;

    // rem < divisor always holds, so a 33-bit difference keeps its top bit as the borrow.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (load) begin
            quo_d     = (is_signed && a[XLEN-1]) ? -a : a;
            dvs_d     = (is_signed && b[XLEN-1]) ? -b : b;
            rem_d     = '0;
            neg_quo_d = is_signed && (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem_d = is_signed && a[XLEN-1];
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_mdu.sv
// EX-stage iterative multiply/divide unit: fixed 33-cycle latency for real work,
// immediate completion for divide-by-zero and signed overflow.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output mdu_state_e      state_dbg
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     mplier_q, mplier_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept, a_signed, b_signed, div_signed, div_zero, div_ovf;
    logic              div_load, div_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_quo, div_rem;

    // Handshake: start is taken in IDLE (flush low); busy stalls the pipe from that
    // cycle through CALC; valid pulses one cycle in DONE with result already final.
    assign accept     = (state_q == IDLE) && start && !flush;
    assign a_signed   = (op == MULH) || (op == MULHSU);
    assign b_signed   = (op == MULH);
    assign div_signed = (op == DIV) || (op == REM);
    assign div_zero   = op[2] && (b == '0);
    assign div_ovf    = div_signed && (a == DIV_OVF_A) && (b == ALL_ONES);

    // Bit 32 of the extended multiplier is its sign: it weighs -2^32, hence a subtract.
    assign prod = mplier_q[0] ? (acc_q - mcand_q) : acc_q;

    mdu_div_core #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rstn      (rstn),
        .load      (div_load),
        .step      (div_step),
        .is_signed (div_signed),
        .a         (a),
        .b         (b),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = op;
                    cnt_d = '0;
                    if (div_zero) begin
                        result_d = op[1] ? a : ALL_ONES;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = op[1] ? '0 : DIV_OVF_A;
                        state_d  = DONE;
                    end else begin
                        mcand_d  = a_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
                        mplier_d = {b_signed & b[XLEN-1], b};
                        acc_d    = '0;
                        div_load = 1'b1;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q != LAST_ITER) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    div_step = op_q[2];
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    if (op_q[2]) begin
                        result_d = op_q[1] ? div_rem : div_quo;
                    end else begin
                        result_d = (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy      = rstn && (accept || (state_q == CALC));
    assign valid     = (state_q == DONE) && !flush;
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule
